imem_loader: RTL and testbench
==============================

IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_WIDTH, default 11, word-address width of the instruction SRAM (2048 words).
REQ-002 Parameter DATA_WIDTH, default 32, instruction word width.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset; asynchronous and active-low.
REQ-005 start  input  1  one-cycle pulse; arms a program load.
REQ-006 abort  input  1  one-cycle pulse; cancels any load and returns to IDLE.
REQ-007 byte_valid  input  1  source presents byte_data.
REQ-008 byte_data  input  8  program stream byte.
REQ-009 byte_ready  output  1  loader accepts a byte this cycle when byte_valid is also high.
REQ-010 cntlr_wr  output  1  one-cycle write strobe to the fetch-unit controller write port.
REQ-011 cntlr_waddr  output  ADDR_WIDTH  instruction word address for the write.
REQ-012 cntlr_wr_data  output  DATA_WIDTH  instruction word for the write.
REQ-013 core_run  output  1  high while the loaded program may execute; core held in reset while low.
REQ-014 busy  output  1  high in HDR_LO, HDR_HI, LOAD, CSUM.
REQ-015 err  output  1  high in ERROR.
REQ-016 words_loaded  output  ADDR_WIDTH+1  count of words written in the current load.

Function
REQ-017 Frame format: 16-bit word count N (low byte first), then N words of 4 bytes each (little-endian), then a 4-byte little-endian checksum equal to the sum of all N words mod 2^32.
REQ-018 States: IDLE, HDR_LO, HDR_HI, LOAD, CSUM, RUN, ERROR.
REQ-019 IDLE: start -> HDR_LO; words_loaded cleared to 0, running sum cleared to 0.
REQ-020 HDR_LO: accepted byte stored as N[7:0] -> HDR_HI.
REQ-021 HDR_HI: accepted byte forms N[15:8]; N==0 or N>2^ADDR_WIDTH -> ERROR; else -> LOAD.
REQ-022 LOAD: 2-bit byte counter assembles bytes into bits [8k+7:8k]; on the 4th accepted byte the word is complete.
REQ-023 Cycle after the 4th byte is accepted: cntlr_wr=1 for exactly one cycle, cntlr_waddr=words_loaded (before increment), cntlr_wr_data=assembled word; words_loaded increments and the word is added to the running sum on that same edge.
REQ-024 When words_loaded reaches N on the write edge -> CSUM; else stay in LOAD.
REQ-025 byte_ready=1 in HDR_LO, HDR_HI, LOAD, CSUM (including the write cycle: no stall); 0 in IDLE, RUN, ERROR.
REQ-026 CSUM: assemble 4 bytes as in LOAD; on the 4th byte compare with running sum: equal -> RUN, different -> ERROR; no write issued.
REQ-027 RUN: core_run=1; start -> HDR_LO (core_run drops on that edge, counters and sum cleared).
REQ-028 ERROR: err=1; start -> HDR_LO with counters and sum cleared.
REQ-029 abort in any state -> IDLE on the next edge; pending write in the abort cycle is suppressed; abort has priority over start and over byte acceptance.
REQ-030 start outside IDLE, RUN, ERROR is ignored.
REQ-031 Bytes presented while byte_ready=0 are neither consumed nor stored.
REQ-032 Address wrap impossible: N is bounded to 2^ADDR_WIDTH so cntlr_waddr never exceeds 2^ADDR_WIDTH-1.

Reset
REQ-033 On rst_n low: state=IDLE, cntlr_wr=0, cntlr_waddr=0, cntlr_wr_data=0, core_run=0, err=0, busy=0, byte_ready=0, words_loaded=0, running sum and byte counter 0.
REQ-034 Reset mid-load abandons the frame; words already written stay in the SRAM.

Structure
REQ-035 Shared package holds the state enumeration and the frame constants (header bytes=2, checksum bytes=4).
REQ-036 One sub-module natural: imem_byte_packer (2-bit counter plus 4-byte shift assembly, word_done pulse), reused for LOAD and CSUM.
REQ-037 All outputs registered.

Verification
REQ-038 Bytes 02 00, 13 00 00 00, 93 00 10 00, checksum A6 00 10 00 -> writes addr0=0x00000013, addr1=0x00100093, core_run=1, words_loaded=2.
REQ-039 Header 00 00 -> ERROR, err=1, no cntlr_wr pulse.
REQ-040 N=1, word 0x00000013, checksum 0x00000014 -> one write, then ERROR, core_run=0.
REQ-041 N=2048 with word i=i -> 2048 writes, last at addr 0x7FF, checksum 0x001FFC00 accepted -> RUN.
REQ-042 abort on the same cycle as the 4th byte of word 0 -> no cntlr_wr, state IDLE, byte_ready=0.
REQ-043 rst_n asserted mid-LOAD between clock edges -> all outputs 0 immediately; start after release reloads from address 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared types and frame constants for the instruction-memory loader.
// The frame is a 2-byte word count, N little-endian words, then a 4-byte checksum.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HDR_LO,
        HDR_HI,
        LOAD,
        CSUM,
        RUN,
        ERROR
    } loader_state_t;

    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_BYTES = 4;
    localparam int HDR_BITS   = HDR_BYTES * 8;
    localparam int WORD_BITS  = WORD_BYTES * 8;
    localparam int CSUM_BITS  = CSUM_BYTES * 8;

    // States in which the loader consumes stream bytes.
    function automatic logic is_busy(input loader_state_t s);
        return (s == HDR_LO) || (s == HDR_HI) || (s == LOAD) || (s == CSUM);
    endfunction

endpackage

// File: rtl/imem_byte_packer.sv
// Assembles accepted bytes into little-endian words; word/word_done are
// combinational and valid together on the cycle the last byte is accepted.
module imem_byte_packer
    import imem_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    input  logic                 byte_en,
    input  logic [7:0]           byte_data,
    output logic [WORD_BITS-1:0] word,
    output logic                 word_done
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0]     byte_cnt;
    logic [WORD_BITS-9:0] partial;

    // Bytes shift in from the top so the first byte lands in bits [7:0].
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (clear) begin
            byte_cnt <= '0;
            partial  <= '0;
        end else if (byte_en) begin
            byte_cnt <= byte_cnt + 1'b1;
            partial  <= {byte_data, partial[WORD_BITS-9:8]};
        end
    end

    assign word      = {byte_data, partial};
    assign word_done = byte_en && (byte_cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Streams a checksummed program frame into the instruction SRAM write port,
// then releases the core. Handshake: a byte transfers on a rising edge where
// byte_valid && byte_ready and abort is low; all other bytes are ignored.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  cntlr_wr,
    output logic [ADDR_WIDTH-1:0] cntlr_waddr,
    output logic [DATA_WIDTH-1:0] cntlr_wr_data,
    output logic                  core_run,
    output logic                  busy,
    output logic                  err,
    output logic [ADDR_WIDTH:0]   words_loaded,
    output loader_state_t         dbg_state
);

    localparam int unsigned MAX_WORDS = 2 ** ADDR_WIDTH;

    loader_state_t        state, state_next;
    logic [7:0]           n_lo;
    logic [HDR_BITS-1:0]  n_words;
    logic [HDR_BITS-1:0]  hdr_n;
    logic [CSUM_BITS-1:0] sum;
    logic                 accept;
    logic                 restart;
    logic                 hdr_bad;
    logic                 last_word;
    logic                 pk_en;
    logic                 pk_clear;
    logic [WORD_BITS-1:0] pk_word;
    logic                 pk_done;

    assign accept    = byte_valid && byte_ready && !abort;
    assign restart   = !abort && start && (state == IDLE || state == RUN || state == ERROR);
    assign hdr_n     = {byte_data, n_lo};
    assign hdr_bad   = (hdr_n == '0) || (32'(hdr_n) > MAX_WORDS);
    assign last_word = (32'(words_loaded) + 32'd1) == 32'(n_words);
    assign pk_en     = accept && (state == LOAD || state == CSUM);
    assign pk_clear  = abort || restart;
    assign dbg_state = state;

    imem_byte_packer u_packer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (pk_clear),
        .byte_en   (pk_en),
        .byte_data (byte_data),
        .word      (pk_word),
        .word_done (pk_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE:    if (start) state_next = HDR_LO;
                HDR_LO:  if (accept) state_next = HDR_HI;
                HDR_HI:  if (accept) state_next = hdr_bad ? ERROR : LOAD;
                LOAD:    if (pk_done && last_word) state_next = CSUM;
                CSUM:    if (pk_done) state_next = (pk_word == sum) ? RUN : ERROR;
                RUN:     if (start) state_next = HDR_LO;
                ERROR:   if (start) state_next = HDR_LO;
                default: state_next = IDLE;
            endcase
        end
    end

    // Status outputs are registered from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_ready    <= 1'b0;
            busy          <= 1'b0;
            err           <= 1'b0;
            core_run      <= 1'b0;
            cntlr_wr      <= 1'b0;
            cntlr_waddr   <= '0;
            cntlr_wr_data <= '0;
            words_loaded  <= '0;
            sum           <= '0;
            n_lo          <= '0;
            n_words       <= '0;
        end else begin
            byte_ready <= is_busy(state_next);
            busy       <= is_busy(state_next);
            err        <= (state_next == ERROR);
            core_run   <= (state_next == RUN);
            cntlr_wr   <= (state == LOAD) && pk_done;

            if (restart) begin
                words_loaded <= '0;
                sum          <= '0;
            end
            if (accept && state == HDR_LO) n_lo    <= byte_data;
            if (accept && state == HDR_HI) n_words <= hdr_n;
            if (state == LOAD && pk_done) begin
                cntlr_waddr   <= words_loaded[ADDR_WIDTH-1:0];
                cntlr_wr_data <= DATA_WIDTH'(pk_word);
                words_loaded  <= words_loaded + 1'b1;
                sum           <= sum + CSUM_BITS'(pk_word);
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized frame-level bench for imem_loader with a write scoreboard.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          byte_valid = 1'b0;
    logic [7:0]    byte_data = '0;
    logic          byte_ready;
    logic          cntlr_wr;
    logic [AW-1:0] cntlr_waddr;
    logic [DW-1:0] cntlr_wr_data;
    logic          core_run;
    logic          busy;
    logic          err;
    logic [AW:0]   words_loaded;
    loader_state_t dbg_state;

    int n_tests = 0;
    int n_fail  = 0;
    logic [AW+DW-1:0] exp_q[$];

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .byte_valid    (byte_valid),
        .byte_data     (byte_data),
        .byte_ready    (byte_ready),
        .cntlr_wr      (cntlr_wr),
        .cntlr_waddr   (cntlr_waddr),
        .cntlr_wr_data (cntlr_wr_data),
        .core_run      (core_run),
        .busy          (busy),
        .err           (err),
        .words_loaded  (words_loaded),
        .dbg_state     (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next expected (addr, data).
    always @(negedge clk) begin
        logic [AW+DW-1:0] e;
        if (rst_n && cntlr_wr) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none",
                         cntlr_waddr, cntlr_wr_data);
            end else begin
                e = exp_q.pop_front();
                check("write", {cntlr_waddr, cntlr_wr_data}, e);
            end
        end
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t;
        repeat ($urandom_range(0, 1)) @(negedge clk);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        t = 0;
        while (!byte_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) check("byte_ready_timeout", 64'(byte_ready), 64'd1);
        @(posedge clk);
        #1 byte_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int k = 0; k < 4; k++) send_byte(8'(w >> (8 * k)));
    endtask

    task automatic settle_and_check(input string tag, input bit exp_run, input bit exp_err,
                                    input int exp_wl);
        repeat (3) @(negedge clk);
        check({tag, "_pending_writes"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_core_run"}, 64'(core_run), 64'(exp_run));
        check({tag, "_err"}, 64'(err), 64'(exp_err));
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_byte_ready"}, 64'(byte_ready), 64'd0);
        check({tag, "_words_loaded"}, 64'(words_loaded), 64'(exp_wl));
    endtask

    // Reference model: header check, expected writes, sum and outcome from the frame rules.
    task automatic run_frame(input string tag, input int n, input logic [31:0] w[$],
                             input bit bad_csum);
        logic [31:0] s;
        bit          hdr_ok;
        pulse_start();
        send_byte(8'(n));
        send_byte(8'(n >> 8));
        hdr_ok = (n >= 1) && (n <= 2 ** AW);
        s = 32'd0;
        if (hdr_ok) begin
            for (int i = 0; i < n; i++) begin
                exp_q.push_back({AW'(i), w[i]});
                send_word(w[i]);
                s = s + w[i];
            end
            send_word(bad_csum ? s + 32'd1 : s);
        end
        settle_and_check(tag, hdr_ok && !bad_csum, !(hdr_ok && !bad_csum), hdr_ok ? n : 0);
    endtask

    initial begin
        logic [31:0] w[$];

        #3;
        check("reset_wr", 64'(cntlr_wr), 64'd0);
        check("reset_outputs", 64'({byte_ready, core_run, busy, err}), 64'd0);
        check("reset_addr_data", 64'({cntlr_waddr, cntlr_wr_data}), 64'd0);
        check("reset_words_loaded", 64'(words_loaded), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Bytes offered in IDLE must be ignored.
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h55;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check("idle_state", 64'(dbg_state), 64'(IDLE));
        check("idle_byte_ready", 64'(byte_ready), 64'd0);

        w = '{32'h0000_0013, 32'h0010_0093};
        run_frame("two_word", 2, w, 1'b0);

        // Bytes offered in RUN must be ignored and the core keeps running.
        @(negedge clk);
        byte_valid = 1'b1;
        repeat (4) @(negedge clk);
        byte_valid = 1'b0;
        check("run_hold", 64'(core_run), 64'd1);

        w = {};
        run_frame("zero_hdr", 0, w, 1'b0);
        run_frame("over_hdr", 2 ** AW + 1, w, 1'b0);

        w = '{32'h0000_0013};
        run_frame("bad_csum", 1, w, 1'b1);

        for (int f = 0; f < 6; f++) begin
            int n;
            n = $urandom_range(1, 6);
            w = {};
            for (int i = 0; i < n; i++) w.push_back($urandom);
            run_frame("random", n, w, $urandom_range(0, 3) == 0);
        end

        w = {};
        for (int i = 0; i < 2 ** AW; i++) w.push_back(32'(i));
        run_frame("full_2048", 2 ** AW, w, 1'b0);

        // Abort coinciding with the last byte of word 0.
        pulse_start();
        send_byte(8'h02);
        send_byte(8'h00);
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = 8'h44;
        abort      = 1'b1;
        @(posedge clk);
        #1;
        byte_valid = 1'b0;
        abort      = 1'b0;
        @(negedge clk);
        check("abort_wr", 64'(cntlr_wr), 64'd0);
        check("abort_state", 64'(dbg_state), 64'(IDLE));
        check("abort_byte_ready", 64'(byte_ready), 64'd0);
        repeat (3) @(negedge clk);

        // Asynchronous reset in the middle of LOAD, then reload from address 0.
        pulse_start();
        send_byte(8'h04);
        send_byte(8'h00);
        exp_q.push_back({AW'(0), 32'hCAFE_F00D});
        send_word(32'hCAFE_F00D);
        send_byte(8'hAB);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_outputs", 64'({cntlr_wr, core_run, busy, err, byte_ready}), 64'd0);
        check("async_rst_addr_data", 64'({cntlr_waddr, cntlr_wr_data}), 64'd0);
        check("async_rst_words_loaded", 64'(words_loaded), 64'd0);
        check("async_rst_pending", 64'(exp_q.size()), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        w = '{32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_BEEF};
        run_frame("after_reset", 3, w, 1'b0);

        repeat (5) @(negedge clk);
        check("final_pending", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "watchdog");
    end

endmodule
